// File: rtl/sc_usb_pkg.sv
// Shared USB host types and constants: token PIDs, transaction-scheduler state
// encoding and the packet-TX field bundle.
package sc_usb_pkg;

    localparam logic [3:0] tokenOut   = 4'b0001;
    localparam logic [3:0] tokenIn    = 4'b1001;
    localparam logic [3:0] tokenSof   = 4'b0101;
    localparam logic [3:0] tokenSetup = 4'b1101;

    localparam int UTS_FRAME_NUM_W = 11;

    typedef logic [0:0] utsState_t;
    localparam utsState_t UTS_IDLE = 1'b0;
    localparam utsState_t UTS_WAIT = 1'b1;

    typedef struct packed {
        logic [3:0]                 pid;
        logic [6:0]                 adr;
        logic [3:0]                 epn;
        logic [7:0]                 dat;
        logic [UTS_FRAME_NUM_W-1:0] num;
    } utsTxFields_t;

endpackage

// File: rtl/sc_scbc_uts_if.sv
// Requester bundle plus packet-TX handshake shared by the transaction scheduler.
// The slave modport is the scheduler's view; master is the environment's view.
interface sc_scbc_uts_if
    import sc_usb_pkg::*;
#(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]                  REQ_VALID;
    logic [NREQ*4-1:0]                REQ_PID;
    logic [NREQ*7-1:0]                REQ_ADR;
    logic [NREQ*4-1:0]                REQ_EPN;
    logic [NREQ*8-1:0]                REQ_DAT;
    logic [NREQ*UTS_FRAME_NUM_W-1:0]  REQ_NUM;
    logic [NREQ-1:0]                  REQ_GRANT;
    logic [NREQ-1:0]                  REQ_DONE;
    logic [NREQ-1:0]                  REQ_ERR;

    logic                             PKT_TX_START;
    logic                             PKT_TX_COMP;
    logic [3:0]                       PKT_TX_PID;
    logic [6:0]                       PKT_TX_ADR;
    logic [3:0]                       PKT_TX_EPN;
    logic [7:0]                       PKT_TX_DAT;
    logic [UTS_FRAME_NUM_W-1:0]       PKT_TX_NUM;

    modport slave (
        input  REQ_VALID, REQ_PID, REQ_ADR, REQ_EPN, REQ_DAT, REQ_NUM, PKT_TX_COMP,
        output REQ_GRANT, REQ_DONE, REQ_ERR,
        output PKT_TX_START, PKT_TX_PID, PKT_TX_ADR, PKT_TX_EPN, PKT_TX_DAT, PKT_TX_NUM
    );

    modport master (
        output REQ_VALID, REQ_PID, REQ_ADR, REQ_EPN, REQ_DAT, REQ_NUM, PKT_TX_COMP,
        input  REQ_GRANT, REQ_DONE, REQ_ERR,
        input  PKT_TX_START, PKT_TX_PID, PKT_TX_ADR, PKT_TX_EPN, PKT_TX_DAT, PKT_TX_NUM
    );

endinterface

// File: rtl/sc_scbc_uts_rrarb.sv
// Combinational round-robin arbiter: picks the first valid requester at or after
// the pointer, wrapping, and reports it both one-hot and as an index.
module sc_scbc_uts_rrarb #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  grant_onehot,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [IDX_W-1:0] cand_idx [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand_idx[gi] = IDX_W'((int'(rr_ptr) + gi) % NREQ);
        end
    endgenerate

    // Scan from the farthest offset down so the nearest valid candidate wins.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        grant_any    = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[cand_idx[k]]) begin
                grant_idx = cand_idx[k];
                grant_any = 1'b1;
            end
        end
        if (grant_any) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/sc_scbc_uts.sv
// USB host transaction scheduler: shares the packet-TX port between SOF generation
// and NREQ round-robin requesters, with end-of-frame guard and TX completion timeout.
module sc_scbc_uts
    import sc_usb_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int FRAME_CYCLES = 60000,
    parameter int EOF_GUARD    = 6000,
    parameter int TX_TIMEOUT   = 4096
) (
    input  logic                       ULPICLK,
    input  logic                       ULPIRSTB,
    input  logic                       UPS_OPERATIONAL,
    input  logic                       FT_1MS,
    output logic                       SOF_MISS,
    output logic [UTS_FRAME_NUM_W-1:0] FRAME_NUM,
    sc_scbc_uts_if.slave               bus
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TMR_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int TO_W  = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

    localparam logic [TMR_W-1:0] TMR_MAX    = TMR_W'(FRAME_CYCLES - 1);
    localparam logic [TMR_W-1:0] OPEN_LIMIT = TMR_W'(FRAME_CYCLES - EOF_GUARD);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TX_TIMEOUT - 1);

    utsState_t                  state_q, state_d;
    logic                       sof_pend_q, sof_pend_d;
    logic                       sof_seen_q, sof_seen_d;
    logic                       sof_miss_q, sof_miss_d;
    logic                       start_q, start_d;
    logic                       is_sof_q, is_sof_d;
    logic [TMR_W-1:0]           timer_q, timer_d;
    logic [TO_W-1:0]            to_cnt_q, to_cnt_d;
    logic [IDX_W-1:0]           rr_q, rr_d;
    logic [IDX_W-1:0]           winner_q, winner_d;
    logic [UTS_FRAME_NUM_W-1:0] frame_num_q, frame_num_d;
    utsTxFields_t               tx_q, tx_d;
    logic [NREQ-1:0]            grant_q, grant_d;
    logic [NREQ-1:0]            done_q, done_d;
    logic [NREQ-1:0]            err_q, err_d;

    logic [NREQ-1:0]  arb_onehot;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic [NREQ-1:0]  winner_oh;
    utsTxFields_t     req_slice [NREQ];
    logic             window_open;
    logic             launch_sof;
    logic             launch_data;

    sc_scbc_uts_rrarb #(
        .NREQ (NREQ)
    ) u_rrarb (
        .req_valid    (bus.REQ_VALID),
        .rr_ptr       (rr_q),
        .grant_onehot (arb_onehot),
        .grant_idx    (arb_idx),
        .grant_any    (arb_any)
    );

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign req_slice[gi] = '{
                pid: bus.REQ_PID[4*gi +: 4],
                adr: bus.REQ_ADR[7*gi +: 7],
                epn: bus.REQ_EPN[4*gi +: 4],
                dat: bus.REQ_DAT[8*gi +: 8],
                num: bus.REQ_NUM[UTS_FRAME_NUM_W*gi +: UTS_FRAME_NUM_W]
            };
            assign winner_oh[gi] = (winner_q == IDX_W'(gi));
        end
    endgenerate

    assign window_open = UPS_OPERATIONAL & sof_seen_q & (timer_q < OPEN_LIMIT) & ~sof_pend_q;
    assign launch_sof  = (state_q == UTS_IDLE) & UPS_OPERATIONAL & sof_pend_q;
    assign launch_data = (state_q == UTS_IDLE) & ~launch_sof & window_open & arb_any;

    // Frame timer and SOF bookkeeping run independently of the transaction FSM.
    always_comb begin
        timer_d = timer_q;
        if (FT_1MS) begin
            timer_d = '0;
        end else if (timer_q != TMR_MAX) begin
            timer_d = timer_q + 1'b1;
        end

        sof_pend_d = sof_pend_q;
        sof_miss_d = 1'b0;
        if (launch_sof) begin
            sof_pend_d = 1'b0;
        end
        if (FT_1MS && UPS_OPERATIONAL) begin
            if (sof_pend_q && !launch_sof) begin
                sof_miss_d = 1'b1;
            end
            sof_pend_d = 1'b1;
        end

        sof_seen_d = sof_seen_q | launch_sof;
        if (!UPS_OPERATIONAL) begin
            sof_pend_d = 1'b0;
            sof_seen_d = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        tx_d        = tx_q;
        is_sof_d    = is_sof_q;
        winner_d    = winner_q;
        rr_d        = rr_q;
        to_cnt_d    = to_cnt_q;
        frame_num_d = frame_num_q;
        grant_d     = '0;
        done_d      = '0;
        err_d       = '0;

        case (state_q)
            UTS_IDLE: begin
                if (launch_sof) begin
                    start_d     = 1'b1;
                    tx_d        = '{pid: tokenSof, adr: '0, epn: '0, dat: '0, num: frame_num_q};
                    frame_num_d = frame_num_q + 1'b1;
                    is_sof_d    = 1'b1;
                    to_cnt_d    = '0;
                    state_d     = UTS_WAIT;
                end else if (launch_data) begin
                    start_d  = 1'b1;
                    tx_d     = req_slice[arb_idx];
                    grant_d  = arb_onehot;
                    winner_d = arb_idx;
                    is_sof_d = 1'b0;
                    to_cnt_d = '0;
                    state_d  = UTS_WAIT;
                end
            end

            UTS_WAIT: begin
                to_cnt_d = to_cnt_q + 1'b1;
                // Completion takes precedence over a timeout landing in the same cycle.
                if (bus.PKT_TX_COMP || (to_cnt_q == TO_LAST)) begin
                    start_d = 1'b0;
                    tx_d    = '0;
                    state_d = UTS_IDLE;
                    if (!is_sof_q) begin
                        rr_d = (winner_q == IDX_W'(NREQ - 1)) ? '0 : winner_q + 1'b1;
                        if (bus.PKT_TX_COMP) begin
                            done_d = winner_oh;
                        end else begin
                            err_d = winner_oh;
                        end
                    end
                end
            end

            default: begin
                state_d = UTS_IDLE;
            end
        endcase
    end

    always_ff @(posedge ULPICLK or negedge ULPIRSTB) begin
        if (!ULPIRSTB) begin
            state_q     <= UTS_IDLE;
            sof_pend_q  <= 1'b0;
            sof_seen_q  <= 1'b0;
            sof_miss_q  <= 1'b0;
            start_q     <= 1'b0;
            is_sof_q    <= 1'b0;
            timer_q     <= TMR_MAX;
            to_cnt_q    <= '0;
            rr_q        <= '0;
            winner_q    <= '0;
            frame_num_q <= '0;
            tx_q        <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            sof_pend_q  <= sof_pend_d;
            sof_seen_q  <= sof_seen_d;
            sof_miss_q  <= sof_miss_d;
            start_q     <= start_d;
            is_sof_q    <= is_sof_d;
            timer_q     <= timer_d;
            to_cnt_q    <= to_cnt_d;
            rr_q        <= rr_d;
            winner_q    <= winner_d;
            frame_num_q <= frame_num_d;
            tx_q        <= tx_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign SOF_MISS         = sof_miss_q;
    assign FRAME_NUM        = frame_num_q;
    assign bus.REQ_GRANT    = grant_q;
    assign bus.REQ_DONE     = done_q;
    assign bus.REQ_ERR      = err_q;
    assign bus.PKT_TX_START = start_q;
    assign bus.PKT_TX_PID   = tx_q.pid;
    assign bus.PKT_TX_ADR   = tx_q.adr;
    assign bus.PKT_TX_EPN   = tx_q.epn;
    assign bus.PKT_TX_DAT   = tx_q.dat;
    assign bus.PKT_TX_NUM   = tx_q.num;

endmodule

// File: doc/sc_scbc_uts.md
Name: sc_scbc_uts

Overview:
USB host transaction scheduler. It shares the single packet-TX interface of the packet transmitter between 1 ms SOF generation and NREQ transfer requesters (control/bulk/interrupt engines).
- SOF always has priority.
- Requesters are served round-robin.
- No new data transaction starts inside the end-of-frame guard window.
- Tracks the 11-bit frame number and supervises TX completion with a timeout.

Parameters:
NREQ, 4, number of requesters (1..8)
FRAME_CYCLES, 60000, ULPICLK cycles per 1 ms frame
EOF_GUARD, 6000, cycles before frame end in which no data transaction may start
TX_TIMEOUT, 4096, max cycles to wait for PKT_TX_COMP

Ports:
ULPICLK  in  1  ULPI clock, 60 MHz
ULPIRSTB  in  1  reset, asynchronous, active-low
UPS_OPERATIONAL  in  1  USB port operational
FT_1MS  in  1  one-cycle frame tick
REQ_VALID  in  NREQ  per-requester request, held until REQ_DONE/REQ_ERR
REQ_PID  in  NREQ*4  token PID, requester i at [4i+:4]
REQ_ADR  in  NREQ*7  device address
REQ_EPN  in  NREQ*4  endpoint number
REQ_DAT  in  NREQ*8  data byte / handle
REQ_NUM  in  NREQ*11  byte count
REQ_GRANT  out  NREQ  one-hot, 1-cycle pulse when the transaction is launched
REQ_DONE  out  NREQ  one-hot, 1-cycle pulse on PKT_TX_COMP
REQ_ERR  out  NREQ  one-hot, 1-cycle pulse on timeout
SOF_MISS  out  1  pulse: FT_1MS arrived while an SOF was still pending
FRAME_NUM  out  11  frame number carried by the next SOF
PKT_TX_START  out  1  transaction start level to the packet TX
PKT_TX_COMP  in  1  transaction complete pulse
PKT_TX_PID  out  4  PID
PKT_TX_ADR  out  7  address
PKT_TX_EPN  out  4  endpoint
PKT_TX_DAT  out  8  data
PKT_TX_NUM  out  11  count; carries the frame number for SOF

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0.
  - State Idle; sof_pend=0, sof_seen=0, frame timer saturated, rr pointer 0, FRAME_NUM=0.
- Frame timer: cleared to 0 on FT_1MS, otherwise increments; saturates at FRAME_CYCLES-1.
- sof_pend:
  - Set on FT_1MS & UPS_OPERATIONAL; cleared when the SOF launches.
  - If FT_1MS arrives with sof_pend already 1: pulse SOF_MISS, sof_pend stays 1 (one SOF only).
- Data window open = UPS_OPERATIONAL & sof_seen & timer < FRAME_CYCLES-EOF_GUARD & !sof_pend.
- FSM states: Idle, Wait (typedef utsState_t).
- Idle, priority order:
  - Priority 1: UPS_OPERATIONAL & sof_pend.
    - Next cycle: PKT_TX_START=1, PID=tokenSof, ADR=0, EPN=0, DAT=0, NUM=FRAME_NUM.
    - FRAME_NUM increments (2047 wraps to 0); sof_seen=1; go Wait.
  - Priority 2: data window open & |REQ_VALID.
    - Winner = first valid index at or after rr pointer, wrapping.
    - Next cycle: START=1, fields from the winner's slices, REQ_GRANT[winner]=1 for that one cycle; go Wait.
  - Otherwise stay in Idle.
- Wait:
  - Fields and START are held stable; the timeout counter increments.
  - On PKT_TX_COMP, in the following cycle:
    - START and all fields return to 0.
    - For a data transaction: REQ_DONE[winner] pulses and rr pointer = winner+1 mod NREQ. An SOF leaves the rr pointer unchanged.
    - Go Idle.
  - Timeout: counter reaches TX_TIMEOUT-1 without COMP. Clear outputs as for COMP, REQ_ERR[winner] pulses (no pulse for SOF), rr pointer advances, go Idle.
  - COMP and timeout in the same cycle: COMP wins.
- Minimum gap: Idle is always occupied for at least 1 cycle between transactions, so START deasserts for at least 1 cycle.
- FT_1MS during Wait: only sets sof_pend (and restarts the timer); the SOF launches from the next Idle.
- UPS_OPERATIONAL deasserted:
  - sof_pend and sof_seen cleared; no launches.
  - A transaction already in Wait finishes via COMP or timeout.
- REQ_VALID dropped by a requester mid-Wait: ignored; its DONE/ERR still pulses.
- Latency: request valid in Idle to START = 1 cycle; COMP to START low = 1 cycle.

Decomposition:
- Add to sc_usb_pkg:
  - utsState_t
  - constants UTS_FRAME_NUM_W=11
  - shared transaction-field struct (pid/adr/epn/dat/num)
  - tokenSof is reused.
- Sub-module sc_scbc_uts_rrarb: combinational NREQ-wide round-robin arbiter (valid vector + pointer -> one-hot + index).
- The FSM, timers and frame counter stay in the top level.

Test Plan:
- Operational, FT_1MS, no requests -> START rises 2 cycles after the tick with PID=tokenSof, NUM=0; COMP -> START low next cycle; next SOF carries NUM=1; after 2048 SOFs NUM wraps to 0.
- REQ_VALID=4'b1011 held, each COMP returned 10 cycles after START -> grants in order 0,1,3,0,1,3 with matching REQ_DONE pulses and per-requester fields on PKT_TX_*.
- FT_1MS during an active data transaction -> SOF launches immediately after that COMP, ahead of pending requests; a second FT_1MS before the SOF launches -> SOF_MISS pulse, single SOF sent.
- Requests pending with timer at FRAME_CYCLES-EOF_GUARD (54000) -> no grant until the next SOF completes; request before the first SOF after operational -> no grant.
- PKT_TX_COMP never returned -> START held for exactly TX_TIMEOUT cycles, then REQ_ERR[winner] pulses, START low, and the next requester is granted.
- ULPIRSTB asserted mid-Wait -> all outputs 0 immediately; after release, FRAME_NUM=0 and no data grant until an SOF has been sent.
